// File: rtl/ed25519_sign_driver.sv
// Host-side initiator for ed25519_sign_S_core: word-wise operand load, handshake, result/latency readback.
// Optional ED25519_DRV_KEY_BYTESWAP_EN presents the key operand byte-reversed to the core.
module ed25519_sign_driver #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [1:0]   wr_sel,
    input  logic [3:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         start,
    input  logic         ack,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_addr,
    output logic [31:0]  rd_data,
    output logic         core_ena,
    input  logic         core_ready,
    input  logic         core_comp_done,
    output logic [511:0] hashd_key,
    output logic [511:0] hashd_ram,
    output logic [511:0] hashd_sm,
    input  logic [255:0] core_S
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [511:0]     key_r;
    logic [511:0]     ram_r;
    logic [511:0]     sm_r;
    logic [255:0]     s_r;
    logic [CNT_W-1:0] cnt;
    logic             wr_ok;
    logic [8:0]       wr_lo;
    logic [31:0]      cnt_w;

    assign busy  = (state == S_ISSUE) || (state == S_RUN);
    assign wr_ok = wr_en && ((state == S_IDLE) || (state == S_DONE));
    assign wr_lo = {wr_addr, 5'd0};
    assign cnt_w = 32'(cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r <= '0;
            ram_r <= '0;
            sm_r  <= '0;
        end else if (wr_ok) begin
            case (wr_sel)
                2'd0:    key_r[wr_lo +: 32] <= wr_data;
                2'd1:    ram_r[wr_lo +: 32] <= wr_data;
                2'd2:    sm_r[wr_lo +: 32]  <= wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            core_ena <= 1'b0;
            done     <= 1'b0;
            s_r      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ISSUE;
                        core_ena <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (core_ready) begin
                        state    <= S_RUN;
                        core_ena <= 1'b0;
                        cnt      <= '0;
                    end
                end
                S_RUN: begin
                    // The completion edge itself is counted, hence the increment is unconditional here.
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (core_comp_done) begin
                        state <= S_DONE;
                        s_r   <= core_S;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state    <= S_ISSUE;
                        core_ena <= 1'b1;
                        done     <= 1'b0;
                    end else if (ack) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (!rd_addr[3]) begin
            rd_data = s_r[{rd_addr[2:0], 5'd0} +: 32];
        end else if (rd_addr == 4'd8) begin
            rd_data = cnt_w;
        end
    end

    assign hashd_ram = ram_r;
    assign hashd_sm  = sm_r;

`ifdef ED25519_DRV_KEY_BYTESWAP_EN
    always_comb begin
        hashd_key = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            hashd_key[8*(63-i) +: 8] = key_r[8*i +: 8];
        end
    end
`else
    assign hashd_key = key_r;
`endif

endmodule

// File: tb/tb_ed25519_sign_driver.sv
// Directed bench for ed25519_sign_driver; results are checked by a done-triggered scoreboard monitor.
module tb_ed25519_sign_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [1:0]   wr_sel;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         start;
    logic         ack;
    logic         busy;
    logic         done;
    logic [3:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         core_ena;
    logic         core_ready;
    logic         core_comp_done;
    logic [511:0] hashd_key;
    logic [511:0] hashd_ram;
    logic [511:0] hashd_sm;
    logic [255:0] core_S;

    logic [3:0]   stim_addr;
    logic [3:0]   mon_addr;
    logic         mon_active = 1'b0;
    int           results_seen = 0;
    int           total = 0;
    int           bad = 0;

    typedef struct {
        logic [255:0] s;
        logic [31:0]  cnt;
    } result_t;
    result_t sb[$];

    localparam logic [255:0] PAT1 = 256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;
    localparam logic [255:0] PAT2 = 256'hF0E1D2C3B4A5968778695A4B3C2D1E0F00112233445566778899AABBCCDDEEFF;
    localparam logic [255:0] PAT3 = 256'h1111111122222222333333334444444455555555666666667777777788888888;

    assign rd_addr = mon_active ? mon_addr : stim_addr;

    ed25519_sign_driver #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .ack(ack), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .core_ena(core_ena), .core_ready(core_ready),
        .core_comp_done(core_comp_done), .hashd_key(hashd_key), .hashd_ram(hashd_ram),
        .hashd_sm(hashd_sm), .core_S(core_S)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [255:0] s, input logic [31:0] c);
        result_t r;
        r.s   = s;
        r.cnt = c;
        sb.push_back(r);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_result(input int n);
        int k;
        k = 0;
        while (results_seen < n && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("result_seen", 256'(results_seen), 256'(n));
    endtask

    // Monitor: every rising done pops one expected result and reads it back over the read port.
    always @(posedge done) begin
        result_t r;
        #1;
        check("sb_pending", 256'(sb.size() > 0), 256'(1));
        if (sb.size() > 0) begin
            r = sb.pop_front();
            mon_active = 1'b1;
            for (int w = 0; w < 8; w++) begin
                mon_addr = 4'(w);
                #1;
                check($sformatf("s_word%0d", w), 256'(rd_data), 256'(r.s[32*w +: 32]));
            end
            mon_addr = 4'd8;
            #1;
            check("latency", 256'(rd_data), 256'(r.cnt));
            mon_active = 1'b0;
        end
        results_seen++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; ack = 1'b0; core_ready = 1'b0; core_comp_done = 1'b0;
        core_S = '0; stim_addr = '0; mon_addr = '0;
        #12;
        check("rst_core_ena", 256'(core_ena), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_key", 256'(hashd_key != '0), 256'(0));
        for (int a = 0; a < 16; a++) begin
            stim_addr = 4'(a);
            #1;
            check($sformatf("rst_rd%0d", a), 256'(rd_data), 256'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Operand loading
        wr(2'd0, 4'd0, 32'h03020100);
        wr(2'd0, 4'd15, 32'hDEADBEEF);
        wr(2'd1, 4'd3, 32'h11112222);
        wr(2'd2, 4'd7, 32'h33334444);
        wr(2'd3, 4'd1, 32'h55555555);
`ifdef ED25519_DRV_KEY_BYTESWAP_EN
        check("key_hi", 256'(hashd_key[511:480]), 256'(32'h00010203));
        check("key_lo", 256'(hashd_key[31:0]), 256'(32'hEFBEADDE));
`else
        check("key_lo", 256'(hashd_key[31:0]), 256'(32'h03020100));
        check("key_hi", 256'(hashd_key[511:480]), 256'(32'hDEADBEEF));
`endif
        check("ram_w3", 256'(hashd_ram[127:96]), 256'(32'h11112222));
        check("sm_w7", 256'(hashd_sm[255:224]), 256'(32'h33334444));
        check("sel3_ignored", 256'(hashd_ram[63:32] | hashd_sm[63:32]), 256'(0));

        // Run 1: core_ready already high, completion on 5th edge after transfer
        core_ready = 1'b1; core_S = PAT1;
        push(PAT1, 32'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("r1_ena_up", 256'(core_ena), 256'(1));
        check("r1_busy", 256'(busy), 256'(1));
        @(negedge clk);
        check("r1_ena_1cyc", 256'(core_ena), 256'(0));
        check("r1_busy_run", 256'(busy), 256'(1));
        repeat (4) @(negedge clk);
        check("r1_not_done", 256'(done), 256'(0));
        core_comp_done = 1'b1;
        @(negedge clk);
        core_comp_done = 1'b0;
        check("r1_done", 256'(done), 256'(1));
        check("r1_busy_done", 256'(busy), 256'(0));
        wait_result(1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("r1_ack_done", 256'(done), 256'(0));
        check("r1_ack_busy", 256'(busy), 256'(0));

        // Run 2: core_ready held low for 10 cycles; start/write ignored while busy
        core_ready = 1'b0; core_S = PAT2;
        push(PAT2, 32'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("r2_ena_hold%0d", i), 256'(core_ena), 256'(1));
            check($sformatf("r2_busy%0d", i), 256'(busy), 256'(1));
            if (i == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
`ifdef ED25519_DRV_KEY_BYTESWAP_EN
        check("r2_key_kept", 256'(hashd_key[511:480]), 256'(32'h00010203));
`else
        check("r2_key_kept", 256'(hashd_key[31:0]), 256'(32'h03020100));
`endif
        core_ready = 1'b1;
        @(negedge clk);
        check("r2_transfer", 256'(core_ena), 256'(0));
        core_ready = 1'b0;
        start = 1'b1; wr_en = 1'b1; wr_sel = 2'd2; wr_addr = 4'd7; wr_data = 32'h0;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check("r2_sm_kept", 256'(hashd_sm[255:224]), 256'(32'h33334444));
        check("r2_run_busy", 256'(busy), 256'(1));
        @(negedge clk);
        core_comp_done = 1'b1;
        @(negedge clk);
        core_comp_done = 1'b0;
        check("r2_done", 256'(done), 256'(1));
        wait_result(2);

        // start and ack together in DONE: restart wins
        core_S = PAT3;
        push(PAT3, 32'd1);
        start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        check("sa_done_clr", 256'(done), 256'(0));
        check("sa_busy", 256'(busy), 256'(1));
        check("sa_ena", 256'(core_ena), 256'(1));
        core_ready = 1'b1;
        @(negedge clk);
        check("sa_transfer", 256'(core_ena), 256'(0));
        core_comp_done = 1'b1;
        @(negedge clk);
        core_comp_done = 1'b0;
        check("sa_done", 256'(done), 256'(1));
        wait_result(3);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Asynchronous reset during ISSUE
        core_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ar_ena_pre", 256'(core_ena), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("ar_ena_async", 256'(core_ena), 256'(0));
        check("ar_busy_async", 256'(busy), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset during RUN, then a late completion is ignored
        core_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ar_run_busy", 256'(busy), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("ar_run_busy_clr", 256'(busy), 256'(0));
        check("ar_run_done_clr", 256'(done), 256'(0));
        check("ar_key_clr", 256'(hashd_key != '0), 256'(0));
        @(negedge clk);
        rst = 1'b0; core_ready = 1'b0;
        core_comp_done = 1'b1;
        repeat (2) @(negedge clk);
        core_comp_done = 1'b0;
        check("ar_late_done", 256'(done), 256'(0));
        check("ar_late_busy", 256'(busy), 256'(0));
        stim_addr = 4'd0;
        #1;
        check("ar_s_clr", 256'(rd_data), 256'(0));
        stim_addr = 4'd8;
        #1;
        check("ar_cnt_clr", 256'(rd_data), 256'(0));

        repeat (2) @(negedge clk);
        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
